// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering controller strobes after a fixed,
// programmable latency, with a busy/valid handshake and out-of-range error flag.
module data_mem_responder #(
    parameter int DATAWIDTH = 16,
    parameter int ADDRWIDTH = 8,   // must be < DATAWIDTH
    parameter int LATENCY   = 2    // 1..15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 memen,
    input  logic                 memwrite,
    input  logic [DATAWIDTH-1:0] memsel,
    input  logic [DATAWIDTH-1:0] memout,
    output logic [DATAWIDTH-1:0] memin,
    output logic                 busy,
    output logic                 valid,
    output logic                 err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]           state;
    logic [3:0]           cnt;
    logic [DATAWIDTH-1:0] lat_addr;
    logic [DATAWIDTH-1:0] lat_data;
    logic                 lat_wr;
    logic [DATAWIDTH-1:0] mem [2**ADDRWIDTH];

    logic                 in_range;
    logic [ADDRWIDTH-1:0] idx;
    logic                 accept;
    logic                 complete;

    assign in_range = (lat_addr[DATAWIDTH-1:ADDRWIDTH] == '0);
    assign idx      = lat_addr[ADDRWIDTH-1:0];
    assign accept   = en && memen && ((state == IDLE) || (state == RESP));
    assign complete = en && (state == WAIT) && (cnt == 4'd0);

    assign busy  = (state == WAIT);
    assign valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            memin <= '0;
            err   <= 1'b0;
        end else if (en) begin
            if (accept) begin
                lat_addr <= memsel;
                lat_data <= memout;
                lat_wr   <= memwrite;
                cnt      <= 4'(LATENCY - 1);
                state    <= WAIT;
            end else begin
                case (state)
                    WAIT: begin
                        if (cnt != 4'd0) begin
                            cnt <= cnt - 4'd1;
                        end else begin
                            state <= RESP;
                            if (!in_range) begin
                                memin <= '0;
                                err   <= 1'b1;
                            end else if (lat_wr) begin
                                memin <= lat_data;   // write echoes the stored word
                                err   <= 1'b0;
                            end else begin
                                memin <= mem[idx];
                                err   <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Storage is deliberately not reset; reset only blocks a pending commit.
    always_ff @(posedge clk) begin
        if (!rst && complete && lat_wr && in_range)
            mem[idx] <= lat_data;
    end

endmodule
